// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: write-back select codes,
// handshake FSM state encoding and the forwarding-select helper.
package mem_access_stage_pkg;

  localparam logic [1:0] WB_SEL_ALU = 2'b00;
  localparam logic [1:0] WB_SEL_MEM = 2'b01;
  localparam logic [1:0] WB_SEL_PC4 = 2'b10;

  typedef enum logic {
    MEM_IDLE = 1'b0,
    MEM_WAIT = 1'b1
  } mem_state_e;

  // The reserved select 2'b11 falls through to the ALU result.
  function automatic logic [31:0] fwd_select(input logic [1:0]  sel,
                                             input logic [31:0] pc_plus_4,
                                             input logic [31:0] alu_result);
    return (sel == WB_SEL_PC4) ? pc_plus_4 : alu_result;
  endfunction

endpackage

// File: rtl/mem_access_stage_dmem_handshake_fsm.sv
// Data-memory req/ready handshake: IDLE/WAIT state, watchdog counter,
// request and stall generation, and the complete/timeout pulses.
module dmem_handshake_fsm
  import mem_access_stage_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 7
) (
  input  logic clk,
  input  logic rst,
  input  logic i_mem_op,
  input  logic i_ready,
  output logic o_req,
  output logic o_stall,
  output logic o_complete,
  output logic o_timeout
);

  if ((2 ** CNT_W) <= TIMEOUT_CYCLES) begin : g_bad_cnt_w
    $error("CNT_W too narrow for TIMEOUT_CYCLES");
  end

  localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  mem_state_e       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             w_req;
  logic             w_timeout;

  // Request is combinational so a zero-wait access completes in its first
  // cycle; reset kills it immediately rather than waiting for an edge.
  assign w_req      = ~rst & ((r_state == MEM_WAIT) | i_mem_op);
  assign w_timeout  = ~rst & (r_state == MEM_WAIT) & ~i_ready & (r_cnt == LP_CNT_LAST);

  assign o_req      = w_req;
  assign o_complete = w_req & i_ready;
  assign o_timeout  = w_timeout;
  assign o_stall    = w_req & ~i_ready & ~w_timeout;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= MEM_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        MEM_IDLE: begin
          if (i_mem_op && !i_ready) begin
            r_state <= MEM_WAIT;
            r_cnt   <= '0;
          end
        end
        MEM_WAIT: begin
          if (i_ready || w_timeout) begin
            r_state <= MEM_IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state <= MEM_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// Pipeline MEM stage: issues word loads/stores over a req/ready port, stalls
// upstream while waiting, and registers results into MEM/WB.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       ex_pc_plus_4_in,
  input  logic [31:0]       ex_alu_result_in,
  input  logic [31:0]       ex_read_data2_in,
  input  logic [4:0]        ex_rd_addr_in,
  input  logic              ex_mem_read_in,
  input  logic              ex_mem_write_in,
  input  logic              ex_reg_write_in,
  input  logic [1:0]        ex_mem_to_reg_in,
  output logic              dmem_req_out,
  output logic              dmem_we_out,
  output logic [ADDR_W-1:0] dmem_addr_out,
  output logic [31:0]       dmem_wdata_out,
  input  logic [31:0]       dmem_rdata_in,
  input  logic              dmem_ready_in,
  output logic              mem_stall_out,
  output logic [31:0]       mem_forward_data_out,
  output logic              mem_bus_error_out,
  output logic [31:0]       wb_pc_plus_4_out,
  output logic [31:0]       wb_alu_result_out,
  output logic [31:0]       wb_mem_data_out,
  output logic [4:0]        wb_rd_addr_out,
  output logic              wb_reg_write_out,
  output logic [1:0]        wb_mem_to_reg_out
);

  logic        w_mem_op;
  logic        w_is_load;
  logic        w_req;
  logic        w_stall;
  logic        w_complete;
  logic        w_timeout;
  logic [31:0] w_load_data;

  logic [31:0] r_wb_pc_plus_4;
  logic [31:0] r_wb_alu_result;
  logic [31:0] r_wb_mem_data;
  logic [4:0]  r_wb_rd_addr;
  logic        r_wb_reg_write;
  logic [1:0]  r_wb_mem_to_reg;
  logic        r_bus_error;

  // Read+write together is a store, so only a pure read returns data.
  assign w_mem_op  = ex_mem_read_in | ex_mem_write_in;
  assign w_is_load = ex_mem_read_in & ~ex_mem_write_in;

  dmem_handshake_fsm #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_W         (CNT_W)
  ) u_fsm (
    .clk       (clk),
    .rst       (rst),
    .i_mem_op  (w_mem_op),
    .i_ready   (dmem_ready_in),
    .o_req     (w_req),
    .o_stall   (w_stall),
    .o_complete(w_complete),
    .o_timeout (w_timeout)
  );

  // Address/data come straight from EX/MEM, which upstream holds while stalled.
  assign dmem_req_out   = w_req;
  assign dmem_we_out    = w_req & ex_mem_write_in;
  assign dmem_addr_out  = {ex_alu_result_in[ADDR_W-1:2], 2'b00};
  assign dmem_wdata_out = ex_read_data2_in;
  assign mem_stall_out  = w_stall;

  assign mem_forward_data_out = fwd_select(ex_mem_to_reg_in, ex_pc_plus_4_in, ex_alu_result_in);

  // A timed-out load never asserts complete, so it writes back zero.
  assign w_load_data = (w_is_load && w_complete) ? dmem_rdata_in : 32'h0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wb_pc_plus_4  <= '0;
      r_wb_alu_result <= '0;
      r_wb_mem_data   <= '0;
      r_wb_rd_addr    <= '0;
      r_wb_reg_write  <= 1'b0;
      r_wb_mem_to_reg <= WB_SEL_ALU;
    end else if (w_stall) begin
      r_wb_rd_addr    <= '0;
      r_wb_reg_write  <= 1'b0;
      r_wb_mem_to_reg <= WB_SEL_ALU;
    end else begin
      r_wb_pc_plus_4  <= ex_pc_plus_4_in;
      r_wb_alu_result <= ex_alu_result_in;
      r_wb_mem_data   <= w_load_data;
      r_wb_rd_addr    <= ex_rd_addr_in;
      r_wb_reg_write  <= ex_reg_write_in;
      r_wb_mem_to_reg <= ex_mem_to_reg_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bus_error <= 1'b0;
    end else if (w_timeout) begin
      r_bus_error <= 1'b1;
    end
  end

  assign wb_pc_plus_4_out  = r_wb_pc_plus_4;
  assign wb_alu_result_out = r_wb_alu_result;
  assign wb_mem_data_out   = r_wb_mem_data;
  assign wb_rd_addr_out    = r_wb_rd_addr;
  assign wb_reg_write_out  = r_wb_reg_write;
  assign wb_mem_to_reg_out = r_wb_mem_to_reg;
  assign mem_bus_error_out = r_bus_error;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: a hand-written vector table, then
// random transactions checked against a latency-based reference model.
module tb_mem_access_stage;

  localparam int T = 4;

  logic        clk;
  logic        rst;
  logic [31:0] ex_pc_plus_4_in;
  logic [31:0] ex_alu_result_in;
  logic [31:0] ex_read_data2_in;
  logic [4:0]  ex_rd_addr_in;
  logic        ex_mem_read_in;
  logic        ex_mem_write_in;
  logic        ex_reg_write_in;
  logic [1:0]  ex_mem_to_reg_in;
  logic        dmem_req_out;
  logic        dmem_we_out;
  logic [31:0] dmem_addr_out;
  logic [31:0] dmem_wdata_out;
  logic [31:0] dmem_rdata_in;
  logic        dmem_ready_in;
  logic        mem_stall_out;
  logic [31:0] mem_forward_data_out;
  logic        mem_bus_error_out;
  logic [31:0] wb_pc_plus_4_out;
  logic [31:0] wb_alu_result_out;
  logic [31:0] wb_mem_data_out;
  logic [4:0]  wb_rd_addr_out;
  logic        wb_reg_write_out;
  logic [1:0]  wb_mem_to_reg_out;

  mem_access_stage #(
    .ADDR_W        (32),
    .TIMEOUT_CYCLES(T),
    .CNT_W         (3)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .ex_pc_plus_4_in     (ex_pc_plus_4_in),
    .ex_alu_result_in    (ex_alu_result_in),
    .ex_read_data2_in    (ex_read_data2_in),
    .ex_rd_addr_in       (ex_rd_addr_in),
    .ex_mem_read_in      (ex_mem_read_in),
    .ex_mem_write_in     (ex_mem_write_in),
    .ex_reg_write_in     (ex_reg_write_in),
    .ex_mem_to_reg_in    (ex_mem_to_reg_in),
    .dmem_req_out        (dmem_req_out),
    .dmem_we_out         (dmem_we_out),
    .dmem_addr_out       (dmem_addr_out),
    .dmem_wdata_out      (dmem_wdata_out),
    .dmem_rdata_in       (dmem_rdata_in),
    .dmem_ready_in       (dmem_ready_in),
    .mem_stall_out       (mem_stall_out),
    .mem_forward_data_out(mem_forward_data_out),
    .mem_bus_error_out   (mem_bus_error_out),
    .wb_pc_plus_4_out    (wb_pc_plus_4_out),
    .wb_alu_result_out   (wb_alu_result_out),
    .wb_mem_data_out     (wb_mem_data_out),
    .wb_rd_addr_out      (wb_rd_addr_out),
    .wb_reg_write_out    (wb_reg_write_out),
    .wb_mem_to_reg_out   (wb_mem_to_reg_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // lat = cycle index (0 = first request cycle) on which ready is pulsed.
  typedef struct packed {
    logic [31:0] pc4;
    logic [31:0] alu;
    logic [31:0] rs2;
    logic [31:0] rdata;
    logic [4:0]  rd;
    logic        rw;
    logic        mr;
    logic        mw;
    logic [1:0]  mtr;
    int          lat;
  } txn_t;

  typedef struct packed {
    logic [31:0] fwd;
    logic [31:0] addr;
    logic [31:0] wb_mem;
    int          stall_n;
    logic        tmo;
  } exp_t;

  typedef struct packed {
    txn_t t;
    exp_t e;
  } vec_t;

  int          n_checks;
  int          n_errors;
  logic        exp_err;
  logic [31:0] hold_pc;
  logic [31:0] hold_alu;
  logic [31:0] hold_mem;
  vec_t        vecs [9];

  task automatic check(input string name, input string field,
                       input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s.%s actual=%h expected=%h", name, field, act, exp);
    end
  endtask

  // Reference: the access finishes on cycle min(lat, T); ready exactly at T
  // still wins, anything later is a forced timeout with zero data.
  function automatic exp_t model(input txn_t t);
    exp_t e;
    logic op;
    op        = t.mr | t.mw;
    e.fwd     = (t.mtr == 2'b10) ? t.pc4 : t.alu;
    e.addr    = {t.alu[31:2], 2'b00};
    e.tmo     = op && (t.lat > T);
    e.stall_n = !op ? 0 : ((t.lat < T) ? t.lat : T);
    e.wb_mem  = (op && !t.mw && !e.tmo) ? t.rdata : 32'h0;
    return e;
  endfunction

  task automatic check_wb_zero(input string name);
    check(name, "wb_pc", wb_pc_plus_4_out, 32'h0);
    check(name, "wb_alu", wb_alu_result_out, 32'h0);
    check(name, "wb_mem", wb_mem_data_out, 32'h0);
    check(name, "wb_rd", {27'h0, wb_rd_addr_out}, 32'h0);
    check(name, "wb_rw", {31'h0, wb_reg_write_out}, 32'h0);
    check(name, "wb_mtr", {30'h0, wb_mem_to_reg_out}, 32'h0);
    check(name, "bus_err", {31'h0, mem_bus_error_out}, 32'h0);
  endtask

  // Called at posedge+1; leaves at posedge+1 after the completion edge.
  task automatic run_txn(input string name, input txn_t t, input exp_t e);
    logic op;
    op               = t.mr | t.mw;
    ex_pc_plus_4_in  = t.pc4;
    ex_alu_result_in = t.alu;
    ex_read_data2_in = t.rs2;
    ex_rd_addr_in    = t.rd;
    ex_reg_write_in  = t.rw;
    ex_mem_read_in   = t.mr;
    ex_mem_write_in  = t.mw;
    ex_mem_to_reg_in = t.mtr;
    dmem_rdata_in    = t.rdata;
    for (int k = 0; k <= e.stall_n; k++) begin
      dmem_ready_in = op ? (k == t.lat) : 1'($urandom_range(0, 1));
      #1;
      check(name, "req", {31'h0, dmem_req_out}, {31'h0, op});
      if (op) begin
        check(name, "addr", dmem_addr_out, e.addr);
        check(name, "we", {31'h0, dmem_we_out}, {31'h0, t.mw});
        check(name, "wdata", dmem_wdata_out, t.rs2);
      end
      check(name, "stall", {31'h0, mem_stall_out}, {31'h0, (k < e.stall_n)});
      check(name, "fwd", mem_forward_data_out, e.fwd);
      @(posedge clk);
      #1;
      if (k < e.stall_n) begin
        check(name, "bubble_rw", {31'h0, wb_reg_write_out}, 32'h0);
        check(name, "bubble_rd", {27'h0, wb_rd_addr_out}, 32'h0);
        check(name, "bubble_mtr", {30'h0, wb_mem_to_reg_out}, 32'h0);
        check(name, "hold_alu", wb_alu_result_out, hold_alu);
        check(name, "hold_mem", wb_mem_data_out, hold_mem);
      end else begin
        hold_pc  = t.pc4;
        hold_alu = t.alu;
        hold_mem = e.wb_mem;
        exp_err  = exp_err | e.tmo;
        check(name, "wb_pc", wb_pc_plus_4_out, hold_pc);
        check(name, "wb_alu", wb_alu_result_out, hold_alu);
        check(name, "wb_mem", wb_mem_data_out, hold_mem);
        check(name, "wb_rd", {27'h0, wb_rd_addr_out}, {27'h0, t.rd});
        check(name, "wb_rw", {31'h0, wb_reg_write_out}, {31'h0, t.rw});
        check(name, "wb_mtr", {30'h0, wb_mem_to_reg_out}, {30'h0, t.mtr});
        check(name, "bus_err", {31'h0, mem_bus_error_out}, {31'h0, exp_err});
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    exp_err  = 1'b0;
    hold_pc  = '0;
    hold_alu = '0;
    hold_mem = '0;

    // pc4, alu, rs2, rdata, rd, rw, mr, mw, mtr, lat | fwd, addr, wb_mem, stall_n, tmo
    vecs[0] = '{'{32'h4, 32'h10, 32'hAAAA, 32'h5555_5555, 5'd5, 1'b1, 1'b0, 1'b0, 2'b00, 0},
                '{32'h10, 32'h10, 32'h0, 0, 1'b0}};
    vecs[1] = '{'{32'h8, 32'h104, 32'h0, 32'hDEAD_BEEF, 5'd7, 1'b1, 1'b1, 1'b0, 2'b01, 0},
                '{32'h104, 32'h104, 32'hDEAD_BEEF, 0, 1'b0}};
    vecs[2] = '{'{32'hC, 32'h203, 32'hCAFE_F00D, 32'h1111_2222, 5'd0, 1'b0, 1'b0, 1'b1, 2'b00, 3},
                '{32'h203, 32'h200, 32'h0, 3, 1'b0}};
    vecs[3] = '{'{32'h10, 32'h300, 32'h0, 32'h99, 5'd9, 1'b1, 1'b1, 1'b0, 2'b01, 100},
                '{32'h300, 32'h300, 32'h0, 4, 1'b1}};
    vecs[4] = '{'{32'h14, 32'h40A, 32'h0, 32'h0123_4567, 5'd3, 1'b1, 1'b1, 1'b0, 2'b01, 2},
                '{32'h40A, 32'h408, 32'h0123_4567, 2, 1'b0}};
    vecs[5] = '{'{32'h48, 32'h1234, 32'h0, 32'h0, 5'd1, 1'b1, 1'b0, 1'b0, 2'b10, 0},
                '{32'h48, 32'h1234, 32'h0, 0, 1'b0}};
    vecs[6] = '{'{32'h50, 32'h507, 32'h77, 32'hFFFF_0000, 5'd4, 1'b0, 1'b1, 1'b1, 2'b00, 1},
                '{32'h507, 32'h504, 32'h0, 1, 1'b0}};
    vecs[7] = '{'{32'h60, 32'hABC, 32'h0, 32'h0, 5'd2, 1'b1, 1'b0, 1'b0, 2'b11, 0},
                '{32'hABC, 32'hABC, 32'h0, 0, 1'b0}};
    vecs[8] = '{'{32'h64, 32'h600, 32'h0, 32'hA5A5, 5'd6, 1'b1, 1'b1, 1'b0, 2'b01, 4},
                '{32'h600, 32'h600, 32'hA5A5, 4, 1'b0}};

    // Reset with a load presented: request must stay gated off.
    rst              = 1'b1;
    ex_pc_plus_4_in  = '0;
    ex_alu_result_in = 32'h100;
    ex_read_data2_in = '0;
    ex_rd_addr_in    = '0;
    ex_mem_read_in   = 1'b1;
    ex_mem_write_in  = 1'b0;
    ex_reg_write_in  = 1'b0;
    ex_mem_to_reg_in = 2'b00;
    dmem_rdata_in    = '0;
    dmem_ready_in    = 1'b0;
    #2;
    check("reset", "req", {31'h0, dmem_req_out}, 32'h0);
    check("reset", "stall", {31'h0, mem_stall_out}, 32'h0);
    check_wb_zero("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      run_txn($sformatf("vec%0d", i), vecs[i].t, vecs[i].e);
    end

    for (int i = 0; i < 300; i++) begin
      txn_t t;
      int   kind;
      kind    = $urandom_range(0, 3);
      t.pc4   = $urandom;
      t.alu   = $urandom;
      t.rs2   = $urandom;
      t.rdata = $urandom;
      t.rd    = 5'($urandom);
      t.rw    = 1'($urandom);
      t.mtr   = 2'($urandom);
      t.mr    = (kind == 1) || (kind == 3);
      t.mw    = (kind == 2) || (kind == 3);
      case ($urandom_range(0, 7))
        6:       t.lat = T;
        7:       t.lat = T + 1 + int'($urandom_range(0, 10));
        default: t.lat = int'($urandom_range(0, T - 1));
      endcase
      run_txn($sformatf("rnd%0d", i), t, model(t));
    end

    // Reset in the middle of a waited load abandons it immediately.
    ex_alu_result_in = 32'h700;
    ex_mem_read_in   = 1'b1;
    ex_mem_write_in  = 1'b0;
    ex_reg_write_in  = 1'b1;
    ex_rd_addr_in    = 5'd8;
    dmem_ready_in    = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #3;
    check("mid_rst_pre", "stall", {31'h0, mem_stall_out}, 32'h1);
    rst = 1'b1;
    #1;
    check("mid_rst", "req", {31'h0, dmem_req_out}, 32'h0);
    check("mid_rst", "we", {31'h0, dmem_we_out}, 32'h0);
    check("mid_rst", "stall", {31'h0, mem_stall_out}, 32'h0);
    check_wb_zero("mid_rst");
    @(posedge clk);
    #1;
    rst      = 1'b0;
    exp_err  = 1'b0;
    hold_pc  = '0;
    hold_alu = '0;
    hold_mem = '0;
    begin
      txn_t t;
      t = '{32'h80, 32'h804, 32'h0, 32'h1357_9BDF, 5'd10, 1'b1, 1'b1, 1'b0, 2'b01, 1};
      run_txn("post_rst", t, model(t));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
Pipeline MEM stage of each core. It consumes the EX/MEM register outputs, issues word loads and stores to the core's data-memory port over a req/ready handshake, and registers results into MEM/WB. It stalls the front of the pipeline while an access is outstanding and provides MEM-stage forwarding data to the execute stage. A watchdog bounds every memory wait.

Parameters:
ADDR_W, 32, data-memory byte-address width
TIMEOUT_CYCLES, 64, maximum WAIT cycles before the access is forced to complete with an error
CNT_W, 7, watchdog counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES

Ports:
clk  in  1  core clock; all state updates on posedge
rst  in  1  asynchronous, active-high reset
ex_pc_plus_4_in  in  32  PC+4 from EX/MEM
ex_alu_result_in  in  32  ALU result; used as the byte address for memory ops
ex_read_data2_in  in  32  forwarded rs2; used as store data
ex_rd_addr_in  in  5  destination register
ex_mem_read_in  in  1  load
ex_mem_write_in  in  1  store
ex_reg_write_in  in  1  register-write enable
ex_mem_to_reg_in  in  2  WB select: 00 ALU, 01 memory, 10 PC+4, 11 reserved (treated as ALU)
dmem_req_out  out  1  access request
dmem_we_out  out  1  1 = store
dmem_addr_out  out  ADDR_W  word-aligned address (bits [1:0] forced to 0)
dmem_wdata_out  out  32  store data
dmem_rdata_in  in  32  load data; valid when dmem_ready_in=1
dmem_ready_in  in  1  access complete this cycle
mem_stall_out  out  1  hold PC, IF/ID, ID/EX and EX/MEM
mem_forward_data_out  out  32  combinational forwarding data: PC+4 if mem_to_reg=10, else ALU result
mem_bus_error_out  out  1  sticky: a watchdog timeout occurred
wb_pc_plus_4_out  out  32  MEM/WB PC+4
wb_alu_result_out  out  32  MEM/WB ALU result
wb_mem_data_out  out  32  MEM/WB load data
wb_rd_addr_out  out  5  MEM/WB destination register
wb_reg_write_out  out  1  MEM/WB register-write enable
wb_mem_to_reg_out  out  2  MEM/WB WB select

Behaviour:
- mem_op = ex_mem_read_in | ex_mem_write_in. If both bits are set, the op is a store (we=1).
- State machine (states IDLE, WAIT; reset state IDLE):
  - IDLE, mem_op=0: request low; MEM/WB latches the inputs next edge (latency 1); wb_mem_data_out <= 0.
  - IDLE, mem_op=1: dmem_req_out=1 combinationally in the same cycle. If dmem_ready_in=1, the access completes with zero stall and MEM/WB latches next edge. Otherwise go to WAIT and clear the counter.
  - WAIT: request held with stable addr/we/wdata; the counter increments each cycle.
    - dmem_ready_in=1: complete. MEM/WB latches the op and dmem_rdata_in (rdata latched for loads, 0 for stores). Return to IDLE.
    - Counter reaches TIMEOUT_CYCLES-1 without ready: forced completion. wb_mem_data_out=0, mem_bus_error_out set to 1 (it stays set until rst). Return to IDLE.
- mem_stall_out = dmem_req_out & ~dmem_ready_in & ~timeout_now. It is 0 on the completion cycle so upstream advances the next edge.
- While stalled, MEM/WB receives a bubble every edge: wb_reg_write_out=0, wb_rd_addr_out=0, wb_mem_to_reg_out=00, data fields hold their last values.
- dmem_ready_in is ignored when no request is active.
- Reset values, applied asynchronously on rst:
  - All wb_* outputs 0; mem_bus_error_out 0; counter 0; state IDLE.
  - dmem_req_out, dmem_we_out and mem_stall_out drop immediately. A mid-access reset abandons the access with no retry.
- mem_forward_data_out is purely combinational from the current EX/MEM inputs; it carries no load data.

Decomposition:
- Shared pipeline package holds:
  - the mem_to_reg encodings (WB_SEL_ALU=2'b00, WB_SEL_MEM=2'b01, WB_SEL_PC4=2'b10);
  - the FSM state encodings (MEM_IDLE, MEM_WAIT).
- One sub-module, dmem_handshake_fsm, owns the state register, watchdog counter, req/stall generation and the complete/timeout pulses.
- The MEM/WB register and the forwarding mux stay in mem_access_stage.

Test Plan:
- ALU op: alu_result=0x0000_0010, mem_to_reg=00, rd=5, reg_write=1 -> next edge wb_alu_result=0x10, wb_rd=5; req never asserted; mem_forward_data=0x10.
- Zero-wait load: addr 0x0000_0104, ready tied 1, rdata=0xDEAD_BEEF -> req with addr 0x104 the same cycle, stall=0, next edge wb_mem_data=0xDEAD_BEEF, wb_mem_to_reg=01.
- Store with 3-cycle wait, addr 0x0000_0203: addr_out=0x200, we=1, wdata=rs2.
  - stall=1 for 3 cycles, with req/addr/wdata stable throughout.
  - wb_reg_write=0 bubbles during the wait.
  - Completes when ready pulses.
- Timeout with TIMEOUT_CYCLES=4 and a load that is never acked -> stall is 1 for 4 cycles, then wb_mem_data=0, bus_error=1 and stays 1 through later accesses.
- rst asserted in WAIT mid-load -> req and stall drop the same cycle, all wb_* are 0, state IDLE; the next load after rst release issues cleanly.
- JAL-style op: mem_to_reg=10, pc_plus_4=0x0000_0048 -> mem_forward_data=0x48, wb_pc_plus_4=0x48 next edge, no memory request.
